// File: rtl/core_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : core_ctrl_fsm
//  Purpose  : Multi-cycle control sequencer for the RV32I core. It steps each
//             instruction through FETCH, DECODE, EXEC, an optional MEM access
//             and WB. It drives the IR/PC/RF write strobes and the datapath
//             select lines. It runs the memory req/ack handshakes and halts on
//             system or illegal opcodes and on memory timeouts.
//  Revision : 1.0 - initial release
// ============================================================================
module core_ctrl_fsm #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic        br_taken,
   output logic        imem_req,
   input  logic        imem_ack,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic        rf_we,
   output logic [1:0]  wb_sel,
   output logic [2:0]  state,
   output logic        halt,
   output logic [1:0]  halt_cause,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      S_BOOT   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] c_OP_IARITH = 7'b0010011;
   localparam logic [6:0] c_OP_LUI    = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;
   localparam logic [6:0] c_OP_JALR   = 7'b1100111;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
   localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

   localparam logic [1:0] c_CAUSE_SYS     = 2'd1;
   localparam logic [1:0] c_CAUSE_ILLEGAL = 2'd2;
   localparam logic [1:0] c_CAUSE_TIMEOUT = 2'd3;

   localparam bit               c_TO_EN     = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] c_WAIT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [31:0]        r_instret;
   logic [1:0]         r_halt_cause;
   logic               r_halt;
   logic               r_imem_req;
   logic               r_dmem_req;
   logic               r_dmem_we;
   logic               r_pc_we;
   logic               r_rf_we;
   logic [1:0]         r_pc_sel;
   logic [1:0]         r_wb_sel;

   logic               w_is_load;
   logic               w_is_store;
   logic               w_is_mem;
   logic               w_is_jal;
   logic               w_is_jalr;
   logic               w_is_branch;
   logic               w_is_wb_class;
   logic               w_rf_wr;
   logic [1:0]         w_pc_sel;
   logic [1:0]         w_wb_sel;
   logic               w_imem_ack_v;
   logic               w_dmem_ack_v;
   logic               w_unused;

   // funct3 is carried for future use; no behaviour depends on it yet
   assign w_unused = ^funct3;

   // Opcode classification of the latched instruction
   always_comb begin
      w_is_load     = (opcode == c_OP_LOAD);
      w_is_store    = (opcode == c_OP_STORE);
      w_is_mem      = w_is_load || w_is_store;
      w_is_jal      = (opcode == c_OP_JAL);
      w_is_jalr     = (opcode == c_OP_JALR);
      w_is_branch   = (opcode == c_OP_BRANCH);
      w_is_wb_class = (opcode == c_OP_RTYPE) || (opcode == c_OP_IARITH) ||
                      (opcode == c_OP_LUI)   || (opcode == c_OP_AUIPC)  ||
                      w_is_jal || w_is_jalr || w_is_branch ||
                      (opcode == c_OP_FENCE);
      w_rf_wr       = w_is_load || (opcode == c_OP_RTYPE) || (opcode == c_OP_IARITH) ||
                      (opcode == c_OP_LUI) || (opcode == c_OP_AUIPC) ||
                      w_is_jal || w_is_jalr;
      w_pc_sel      = 2'd0;
      if (w_is_jal || (w_is_branch && br_taken)) begin
         w_pc_sel = 2'd1;
      end else if (w_is_jalr) begin
         w_pc_sel = 2'd2;
      end
      w_wb_sel      = 2'd0;
      if (w_is_load) begin
         w_wb_sel = 2'd1;
      end else if (w_is_jal || w_is_jalr) begin
         w_wb_sel = 2'd2;
      end
   end

   // An ack only counts while the matching request is being driven
   assign w_imem_ack_v = imem_ack && r_imem_req;
   assign w_dmem_ack_v = dmem_ack && r_dmem_req;

   // Sequencer: next state plus registered strobes for the state being entered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_BOOT;
         r_cnt        <= '0;
         r_instret    <= 32'd0;
         r_halt_cause <= 2'd0;
         r_halt       <= 1'b0;
         r_imem_req   <= 1'b0;
         r_dmem_req   <= 1'b0;
         r_dmem_we    <= 1'b0;
         r_pc_we      <= 1'b0;
         r_rf_we      <= 1'b0;
         r_pc_sel     <= 2'd0;
         r_wb_sel     <= 2'd0;
      end else begin
         r_imem_req <= 1'b0;
         r_dmem_req <= 1'b0;
         r_dmem_we  <= 1'b0;
         r_pc_we    <= 1'b0;
         r_rf_we    <= 1'b0;
         r_pc_sel   <= 2'd0;
         r_wb_sel   <= 2'd0;
         case (r_state)
            S_BOOT: begin
               r_state    <= S_FETCH;
               r_cnt      <= '0;
               r_imem_req <= 1'b1;
            end
            S_FETCH: begin
               if (w_imem_ack_v) begin
                  r_state <= S_DECODE;
               end else if (c_TO_EN && (r_cnt == c_WAIT_LAST)) begin
                  r_state      <= S_HALT;
                  r_halt       <= 1'b1;
                  r_halt_cause <= c_CAUSE_TIMEOUT;
               end else begin
                  r_cnt      <= r_cnt + c_CNT_ONE;
                  r_imem_req <= 1'b1;
               end
            end
            S_DECODE: begin
               r_state <= S_EXEC;
            end
            S_EXEC: begin
               if (w_is_mem) begin
                  r_state    <= S_MEM;
                  r_cnt      <= '0;
                  r_dmem_req <= 1'b1;
                  r_dmem_we  <= w_is_store;
               end else if (w_is_wb_class) begin
                  r_state  <= S_WB;
                  r_pc_we  <= 1'b1;
                  r_rf_we  <= w_rf_wr;
                  r_pc_sel <= w_pc_sel;
                  r_wb_sel <= w_wb_sel;
               end else begin
                  r_state      <= S_HALT;
                  r_halt       <= 1'b1;
                  r_halt_cause <= (opcode == c_OP_SYSTEM) ? c_CAUSE_SYS : c_CAUSE_ILLEGAL;
               end
            end
            S_MEM: begin
               if (w_dmem_ack_v) begin
                  r_state  <= S_WB;
                  r_pc_we  <= 1'b1;
                  r_rf_we  <= w_rf_wr;
                  r_pc_sel <= w_pc_sel;
                  r_wb_sel <= w_wb_sel;
               end else if (c_TO_EN && (r_cnt == c_WAIT_LAST)) begin
                  r_state      <= S_HALT;
                  r_halt       <= 1'b1;
                  r_halt_cause <= c_CAUSE_TIMEOUT;
               end else begin
                  r_cnt      <= r_cnt + c_CNT_ONE;
                  r_dmem_req <= 1'b1;
                  r_dmem_we  <= w_is_store;
               end
            end
            S_WB: begin
               r_instret  <= r_instret + 32'd1;
               r_state    <= S_FETCH;
               r_cnt      <= '0;
               r_imem_req <= 1'b1;
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
            default: begin
               r_state <= S_BOOT;
            end
         endcase
      end
   end

   assign state      = r_state;
   assign imem_req   = r_imem_req;
   assign dmem_req   = r_dmem_req;
   assign dmem_we    = r_dmem_we;
   assign ir_we      = (r_state == S_FETCH) && w_imem_ack_v;
   assign pc_we      = r_pc_we;
   assign rf_we      = r_rf_we;
   assign pc_sel     = r_pc_sel;
   assign wb_sel     = r_wb_sel;
   assign halt       = r_halt;
   assign halt_cause = r_halt_cause;
   assign instret    = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_core_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_ctrl_fsm
//  Purpose  : Self-checking bench for core_ctrl_fsm. Each instruction is
//             expanded into a per-cycle trace of stimulus and expected outputs.
//             The trace is then replayed against the DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_core_ctrl_fsm;

   localparam int TIMEOUT  = 64;
   localparam int CNT_W    = 8;
   localparam int HALT_OBS = 4;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IARITH = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic [6:0]  opcode   = 7'd0;
   logic [2:0]  funct3   = 3'd0;
   logic        br_taken = 1'b0;
   logic        imem_ack = 1'b0;
   logic        dmem_ack = 1'b0;
   logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, halt;
   logic [1:0]  pc_sel, wb_sel, halt_cause;
   logic [2:0]  state;
   logic [31:0] instret;

   core_ctrl_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .br_taken(br_taken),
      .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_ack(dmem_ack), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
      .wb_sel(wb_sel), .state(state), .halt(halt), .halt_cause(halt_cause), .instret(instret)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0]  op;
      logic        br;
      logic        iack;
      logic        dack;
      logic [2:0]  st;
      logic        imreq, irwe, dmreq, dmwe, pcwe, rfwe, hlt;
      logic [1:0]  pcsel, wbsel, cause;
      logic [31:0] ir;
   } cyc_t;

   cyc_t        q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] m_instret;
   logic        m_halted;
   logic [1:0]  m_cause;
   int          fetch_seen, dmreq_seen, busy_seen;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic cyc_t blank(input logic [2:0] st, input logic [6:0] op, input logic br);
      cyc_t c;
      c.op = op; c.br = br; c.iack = 1'b0; c.dack = 1'b0; c.st = st;
      c.imreq = 1'b0; c.irwe = 1'b0; c.dmreq = 1'b0; c.dmwe = 1'b0;
      c.pcwe = 1'b0; c.rfwe = 1'b0; c.hlt = m_halted;
      c.pcsel = 2'd0; c.wbsel = 2'd0; c.cause = m_cause; c.ir = m_instret;
      return c;
   endfunction

   // Core halts: a few observed HALT cycles with stray acks that must be ignored
   task automatic push_halt(input logic [1:0] cause, input logic [6:0] op);
      cyc_t c;
      m_halted = 1'b1;
      m_cause  = cause;
      for (int i = 0; i < HALT_OBS; i++) begin
         c = blank(3'd6, op, 1'b0);
         c.iack = 1'b1; c.dack = 1'b1;
         q.push_back(c);
      end
   endtask

   // Expand one instruction into its expected cycle-by-cycle trace
   task automatic model_instr(input logic [6:0] op, input logic br, input int iwait, input int dwait);
      cyc_t c;
      bit   ld, st;
      if (m_halted) return;
      ld = (op == OP_LOAD);
      st = (op == OP_STORE);
      for (int i = 0; i <= iwait; i++) begin
         if (TIMEOUT != 0 && i == TIMEOUT) begin
            push_halt(2'd3, op);
            return;
         end
         c = blank(3'd1, op, br);
         c.imreq = 1'b1; c.iack = (i == iwait); c.irwe = (i == iwait);
         q.push_back(c);
      end
      c = blank(3'd2, op, br);
      c.iack = 1'b1; c.dack = 1'b1;
      q.push_back(c);
      q.push_back(blank(3'd3, op, br));
      if (ld || st) begin
         for (int i = 0; i <= dwait; i++) begin
            if (TIMEOUT != 0 && i == TIMEOUT) begin
               push_halt(2'd3, op);
               return;
            end
            c = blank(3'd4, op, br);
            c.dmreq = 1'b1; c.dmwe = st; c.dack = (i == dwait);
            q.push_back(c);
         end
      end else if (op == OP_SYSTEM) begin
         push_halt(2'd1, op);
         return;
      end else if (!(op inside {OP_RTYPE, OP_IARITH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_FENCE})) begin
         push_halt(2'd2, op);
         return;
      end
      c = blank(3'd5, op, br);
      c.pcwe  = 1'b1;
      c.rfwe  = !(st || op == OP_BRANCH || op == OP_FENCE);
      c.pcsel = (op == OP_JAL || (op == OP_BRANCH && br)) ? 2'd1 : (op == OP_JALR) ? 2'd2 : 2'd0;
      c.wbsel = ld ? 2'd1 : (op == OP_JAL || op == OP_JALR) ? 2'd2 : 2'd0;
      q.push_back(c);
      m_instret = m_instret + 32'd1;
   endtask

   // Replay up to 'limit' trace entries, one per cycle, checking mid-cycle
   task automatic run_queue(input int limit);
      cyc_t c;
      int   n = 0;
      while (q.size() > 0 && n < limit) begin
         c = q.pop_front();
         n++;
         opcode = c.op; br_taken = c.br; imem_ack = c.iack; dmem_ack = c.dack;
         #1;
         if (state == 3'd1) fetch_seen++;
         if (dmem_req) dmreq_seen++;
         if (state != 3'd0 && state != 3'd6) busy_seen++;
         chk($sformatf("outputs@st%0d", c.st),
             {state, imem_req, ir_we, dmem_req, dmem_we & dmem_req, pc_we, rf_we, pc_sel, wb_sel, halt, halt_cause},
             {c.st, c.imreq, c.irwe, c.dmreq, c.dmwe, c.pcwe, c.rfwe, c.pcsel, c.wbsel, c.hlt, c.cause});
         chk($sformatf("instret@st%0d", c.st), instret, c.ir);
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;
      #1;
      chk("reset_state", state, 3'd0);
      chk("reset_instret", instret, 32'd0);
      chk("reset_strobes", {imem_req, dmem_req, ir_we, pc_we, rf_we, halt, halt_cause}, 8'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_instret = 32'd0; m_halted = 1'b0; m_cause = 2'd0;
      fetch_seen = 0; dmreq_seen = 0; busy_seen = 0;
      q.delete();
      q.push_back(blank(3'd0, opcode, 1'b0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Simple ALU op, zero-wait fetch: BOOT, FETCH, DECODE, EXEC, WB
      do_reset();
      model_instr(OP_IARITH, 1'b0, 0, 0);
      run_queue(1000);
      chk("addi_instret_lit", instret, 32'd1);
      chk("addi_cycles_lit", busy_seen, 4);

      // Load with ack on the 4th MEM cycle, then store likewise
      do_reset();
      model_instr(OP_LOAD, 1'b0, 0, 3);
      run_queue(1000);
      chk("load_dmreq_cycles_lit", dmreq_seen, 4);
      model_instr(OP_STORE, 1'b0, 1, 3);
      run_queue(1000);
      chk("ldst_instret_lit", instret, 32'd2);

      // Zero-wait load takes five cycles
      do_reset();
      model_instr(OP_LOAD, 1'b0, 0, 0);
      run_queue(1000);
      chk("load_cycles_lit", busy_seen, 5);

      // Control flow and remaining writeback classes
      do_reset();
      model_instr(OP_BRANCH, 1'b1, 0, 0);
      model_instr(OP_BRANCH, 1'b0, 2, 0);
      model_instr(OP_JALR,   1'b0, 0, 0);
      model_instr(OP_JAL,    1'b1, 1, 0);
      model_instr(OP_LUI,    1'b0, 0, 0);
      model_instr(OP_AUIPC,  1'b0, 0, 0);
      model_instr(OP_FENCE,  1'b0, 0, 0);
      model_instr(OP_RTYPE,  1'b1, 0, 0);
      run_queue(1000);
      chk("mix_instret_lit", instret, 32'd8);

      // Fetch timeout: no ack for 64 cycles
      do_reset();
      model_instr(OP_IARITH, 1'b0, 0, 0);
      model_instr(OP_IARITH, 1'b0, 1000, 0);
      fetch_seen = 0;
      run_queue(1000);
      chk("timeout_fetch_cycles_lit", fetch_seen, 65);
      chk("timeout_cause_lit", halt_cause, 2'd3);
      chk("timeout_instret_lit", instret, 32'd1);

      // Ack on the 64th fetch cycle wins over the timeout
      do_reset();
      model_instr(OP_IARITH, 1'b0, 63, 0);
      run_queue(1000);
      chk("late_ack_nohalt_lit", {halt, instret}, {1'b0, 32'd1});

      // Data-side timeout
      do_reset();
      model_instr(OP_STORE, 1'b0, 0, 1000);
      run_queue(1000);
      chk("dmem_timeout_cause_lit", halt_cause, 2'd3);

      // System opcode halts with cause 1
      do_reset();
      model_instr(OP_IARITH, 1'b0, 0, 0);
      model_instr(OP_SYSTEM, 1'b0, 0, 0);
      run_queue(1000);
      chk("ecall_lit", {halt, halt_cause, instret}, {1'b1, 2'd1, 32'd1});

      // Illegal opcode halts with cause 2
      do_reset();
      model_instr(7'b0000000, 1'b0, 0, 0);
      run_queue(1000);
      chk("illegal_lit", {halt, halt_cause, instret}, {1'b1, 2'd2, 32'd0});

      // Asynchronous reset in the middle of a data handshake
      do_reset();
      model_instr(OP_IARITH, 1'b0, 0, 0);
      model_instr(OP_LOAD, 1'b0, 0, 10);
      run_queue(10);
      #1;
      chk("pre_reset_dmem_req_lit", {state, dmem_req, instret}, {3'd4, 1'b1, 32'd1});
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_reset_lit", {state, dmem_req, instret}, {3'd0, 1'b0, 32'd0});
      do_reset();
      model_instr(OP_IARITH, 1'b0, 0, 0);
      run_queue(1000);
      chk("post_reset_instret_lit", instret, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/core_ctrl_fsm.md
Name: core_ctrl_fsm

Overview:
Multi-cycle control sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, optional data-memory access and writeback, driving the IR/PC/register-file write strobes and the datapath muxes. It handles req/ack handshakes to instruction and data memory and halts on system, illegal or timed-out operations. It sits beside decoder_core and takes opcode/funct3 from the latched instruction.

Parameters:
TIMEOUT, 64, max cycles a memory request may wait for ack before halt; 0 disables timeout
CNT_W, 8, width of wait counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
opcode  in  7  inst[6:0] of latched IR
funct3  in  3  inst[14:12] of latched IR (reserved; no behaviour depends on it this revision)
br_taken  in  1  ALU branch-compare result, valid in EXEC/WB
imem_req  out  1  instruction fetch request
imem_ack  in  1  fetch data valid
dmem_req  out  1  data access request
dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
dmem_ack  in  1  data access complete
ir_we  out  1  latch fetched word into IR
pc_we  out  1  update PC
pc_sel  out  2  0 pc+4, 1 alu_out, 2 {alu_out[31:1],1'b0}
rf_we  out  1  register-file write
wb_sel  out  2  0 alu_out, 1 load data, 2 pc+4
state  out  3  current state (debug)
halt  out  1  core halted, sticky
halt_cause  out  2  0 none, 1 ecall/ebreak/csr, 2 illegal opcode, 3 memory timeout
instret  out  32  retired-instruction counter

Behaviour:
- States: BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encoding 7 is unused; the FSM recovers to BOOT.
- Reset (rst_n low, async): state=BOOT, instret=0, halt_cause=0, wait counter=0. All strobes/reqs 0 immediately, including mid-handshake.
- BOOT: one cycle, all outputs 0 -> FETCH.
- FETCH: imem_req=1, held until imem_ack sampled 1.
  - On ack cycle: ir_we=1 for exactly that cycle; next state DECODE.
- DECODE: one cycle, no strobes -> EXEC.
- EXEC: one cycle; classify opcode:
  - 0000011 load or 0100011 store -> MEM.
  - 0110011, 0010011, 0110111, 0010111, 1101111, 1100111, 1100011, 0001111 -> WB.
  - 1110011 -> HALT, cause 1.
  - Anything else -> HALT, cause 2.
- MEM: dmem_req=1, dmem_we=(opcode==store), held until dmem_ack sampled 1 -> WB.
- WB: one cycle. pc_we=1; instret+=1 (wraps FFFF_FFFF->0).
  - rf_we=1 for R, I-arith, load, lui, auipc, jal, jalr; 0 for store, branch, fence.
  - pc_sel: jal=1, branch with br_taken=1 -> 1, jalr=2, else 0.
  - wb_sel: load=1, jal/jalr=2, else 0.
  - Next state FETCH.
- All strobes are Moore/decode outputs and 0 outside the states above. Only one of ir_we/pc_we/rf_we-phase/dmem_req/imem_req phases is active per state.
- Latency with zero-wait ack: 4 cycles per non-memory instruction, 5 per load/store.
- Timeout: the wait counter clears on entry to FETCH/MEM and increments each waiting cycle without ack.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no ack, go to HALT with cause 3.
  - Ack in that same cycle wins: normal transition.
- Ack while the corresponding req is 0 is ignored.
- HALT: sticky until reset; halt=1, all strobes 0, instret frozen, halt_cause held.

Test Plan:
- Release reset, imem_ack=1 constant, opcode=0010011 -> states 0,1,2,3,5,1; ir_we high in FETCH cycle, rf_we=1/pc_we=1/wb_sel=0/pc_sel=0 for one cycle in WB; instret=1.
- opcode=0000011, dmem_ack asserted on 4th MEM cycle -> dmem_req high 4 cycles, dmem_we=0, then WB with wb_sel=1, rf_we=1. Repeat with opcode=0100011 -> dmem_we=1, rf_we=0.
- opcode=1100011: br_taken=1 -> pc_sel=1, rf_we=0; br_taken=0 -> pc_sel=0. opcode=1100111 -> pc_sel=2, wb_sel=2, rf_we=1. opcode=1101111 -> pc_sel=1, wb_sel=2.
- TIMEOUT=64, imem_ack held 0 -> HALT after 64 FETCH cycles, halt_cause=3, imem_req=0 thereafter. Rerun with ack on 64th cycle -> DECODE, no halt.
- opcode=1110011 -> HALT, cause 1. opcode=0000000 -> HALT, cause 2. In both cases instret unchanged and rf_we never asserted.
- Drop rst_n during MEM with dmem_req high -> dmem_req=0 and state=0 before the next clock edge; instret=0. Release -> BOOT then FETCH.
